// File: rtl/fdd840_trkwr.sv
// 840 floppy write path: paces CPU-written bytes at the disk byte rate into tag+data track-RAM pairs.
// Optional: define FDD840_UNDERRUN_FILL_EN to pad underrun ticks with 0xAA instead of ending the write.
module fdd840_trkwr #(
    parameter int BYTE_PERIOD = 3200,
    parameter int TRACK_LEN   = 6464
) (
    input  logic        clk100,
    input  logic        res,
    input  logic        io_on,
    input  logic        rw,
    input  logic [3:0]  address,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        wp,
    input  logic [7:0]  atrack,
    input  logic [12:0] head_pos,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        flush_req,
    output logic [7:0]  flush_track,
    input  logic        flush_ack
);
    localparam int CW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FLUSH} state_t;
    state_t state_reg, state_next;

    logic          armed_reg;
    logic [CW-1:0] tick_cnt_reg;
    logic [7:0]    hold_reg;
    logic          need_reg;
    logic          sync_pend_reg;
    logic          dirty_reg;
    logic          underrun_reg;
    logic          wp_prev_reg;
    logic [12:0]   pos_reg;
    logic [12:0]   base_reg;
    logic [7:0]    trk_l_reg;
    logic          pair_second_reg;
    logic [12:0]   pair_slot_reg;
    logic [7:0]    pair_tag_reg;

    logic        io_access, wr_access;
    logic        port5_wr, portb_wr, portc_wr;
    logic        hold_load, start;
    logic        tick, emit, underrun_tick, fill, underrun_end;
    logic        wp_rise, dirty_now;
    logic [12:0] slot;

    assign io_access     = io_on & armed_reg;
    assign wr_access     = io_access & ~rw;
    assign port5_wr      = wr_access && (address == 4'h5);
    assign portb_wr      = wr_access && (address == 4'hB);
    assign portc_wr      = wr_access && (address == 4'hC);
    assign hold_load     = port5_wr & ~wp;
    assign start         = hold_load && (state_reg == ST_IDLE);
    assign tick          = (state_reg == ST_WRITE) && (tick_cnt_reg == CW'(BYTE_PERIOD - 1));
    assign emit          = tick & ~need_reg;
    assign underrun_tick = tick & need_reg;
    assign wp_rise       = wp & ~wp_prev_reg;
    assign slot          = base_reg + pos_reg;

`ifdef FDD840_UNDERRUN_FILL_EN
    assign fill         = underrun_tick;
    assign underrun_end = 1'b0;
`else
    assign fill         = 1'b0;
    assign underrun_end = underrun_tick;
`endif

    // A byte emitted on the same edge as a stop request still counts as dirty data.
    assign dirty_now = dirty_reg | emit | fill;

    always_ff @(posedge clk100) begin
        if (res) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (atrack != trk_l_reg)
                    state_next = ST_FLUSH;
                else if (portc_wr || wp_rise || underrun_end)
                    state_next = dirty_now ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (res) begin
            armed_reg       <= 1'b1;
            tick_cnt_reg    <= '0;
            hold_reg        <= 8'h00;
            need_reg        <= 1'b1;
            sync_pend_reg   <= 1'b0;
            dirty_reg       <= 1'b0;
            underrun_reg    <= 1'b0;
            wp_prev_reg     <= 1'b0;
            pos_reg         <= '0;
            base_reg        <= '0;
            trk_l_reg       <= 8'h00;
            pair_second_reg <= 1'b0;
            pair_slot_reg   <= '0;
            pair_tag_reg    <= 8'h00;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= 8'h00;
        end else begin
            wp_prev_reg <= wp;

            if (!io_on)         armed_reg <= 1'b1;
            else if (io_access) armed_reg <= 1'b0;

            if (start || state_reg != ST_WRITE || tick) tick_cnt_reg <= '0;
            else                                        tick_cnt_reg <= tick_cnt_reg + CW'(1);

            // A fresh byte wins over the tick that consumed the previous one.
            if (hold_load) begin
                hold_reg <= din;
                need_reg <= 1'b0;
            end else if (emit) begin
                need_reg <= 1'b1;
            end

            if (portb_wr)  sync_pend_reg <= 1'b1;
            else if (emit) sync_pend_reg <= 1'b0;

            if (state_reg == ST_FLUSH && flush_ack) dirty_reg <= 1'b0;
            else if (emit || fill)                  dirty_reg <= 1'b1;

            if (start)              underrun_reg <= 1'b0;
            else if (underrun_tick) underrun_reg <= 1'b1;

            if (start) begin
                pos_reg   <= head_pos;
                base_reg  <= {5'b00000, atrack[1:0], 6'b000000};
                trk_l_reg <= atrack;
            end else if (emit || fill) begin
                pos_reg <= (pos_reg == 13'(TRACK_LEN - 1)) ? 13'd0 : pos_reg + 13'd1;
            end

            // Data byte goes out the cycle after the tick, its tag the cycle after that.
            if (emit || fill) begin
                wr_en           <= 1'b1;
                wr_addr         <= {slot, 1'b0};
                wr_data         <= emit ? hold_reg : 8'hAA;
                pair_slot_reg   <= slot;
                pair_tag_reg    <= (emit && sync_pend_reg) ? 8'h01 : 8'h00;
                pair_second_reg <= 1'b1;
            end else if (pair_second_reg) begin
                wr_en           <= 1'b1;
                wr_addr         <= {pair_slot_reg, 1'b1};
                wr_data         <= pair_tag_reg;
                pair_second_reg <= 1'b0;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = 8'h00;
        if (io_on && rw && address == 4'h6)
            dout = {need_reg, (state_reg == ST_WRITE), underrun_reg, wp, 4'b0000};
    end

    assign flush_req   = (state_reg == ST_FLUSH);
    assign flush_track = trk_l_reg;

endmodule

// File: tb/tb_fdd840_trkwr.sv
// Self-checking bench for fdd840_trkwr: RAM writes are checked against a queue of expected pairs.
module tb_fdd840_trkwr;
    localparam int BP = 16;

    logic        clk100 = 1'b0;
    logic        res = 1'b1;
    logic        io_on = 1'b0;
    logic        rw = 1'b0;
    logic [3:0]  address = 4'h0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        wp = 1'b0;
    logic [7:0]  atrack = 8'h00;
    logic [12:0] head_pos = 13'h0;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        flush_req;
    logic [7:0]  flush_track;
    logic        flush_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];

    fdd840_trkwr #(.BYTE_PERIOD(BP), .TRACK_LEN(6464)) dut (
        .clk100(clk100), .res(res), .io_on(io_on), .rw(rw), .address(address),
        .din(din), .dout(dout), .wp(wp), .atrack(atrack), .head_pos(head_pos),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .flush_req(flush_req),
        .flush_track(flush_track), .flush_ack(flush_ack)
    );

    always #5 clk100 = ~clk100;

    // Scoreboard: every RAM strobe must match the oldest expected pair entry.
    always @(negedge clk100) begin
        if (wr_en) begin
            logic [21:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ram_write unexpected: addr=%h data=%h, none expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, e[21:8], e[7:0]);
                end else begin
                    $display("ram write addr=%h data=%h", wr_addr, wr_data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk100);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        tick_wait(1);
        io_on = 1'b1; rw = 1'b0; address = a; din = d;
        tick_wait(1);
        io_on = 1'b0;
        $display("cpu write port=%h data=%h", a, d);
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        tick_wait(1);
        io_on = 1'b1; rw = 1'b1; address = a;
        #2 d = dout;
        @(posedge clk100);
        #1;
        io_on = 1'b0; rw = 1'b0;
        $display("cpu read port=%h data=%h", a, d);
    endtask

    task automatic wait_wr_en(input string name);
        int n = 0;
        while (!wr_en && n < 4 * BP) begin
            tick_wait(1);
            n++;
        end
        if (!wr_en) begin
            errors++;
            $display("FAIL %s: wr_en never asserted, got 0 expected 1", name);
        end
    endtask

    task automatic wait_pair(input string name);
        int n = 0;
        wait_wr_en(name);
        while (wr_en && n < 4) begin
            tick_wait(1);
            n++;
        end
    endtask

    task automatic ack_flush();
        tick_wait(1);
        flush_ack = 1'b1;
        tick_wait(1);
        flush_ack = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [7:0] expv);
        logic [7:0] st;
        cpu_read(4'h6, st);
        checks++;
        if (st !== expv) begin
            errors++;
            $display("FAIL %s: status got %h expected %h", name, st, expv);
        end
    endtask

    task automatic check_flush(input string name, input logic req, input logic [7:0] trk);
        checks++;
        if (flush_req !== req || (req && flush_track !== trk)) begin
            errors++;
            $display("FAIL %s: flush_req=%b track=%h expected req=%b track=%h",
                     name, flush_req, flush_track, req, trk);
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        tick_wait(3);
        checks++;
        if ({wr_en, flush_req, flush_track, wr_addr, wr_data, dout} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got wr_en=%b req=%b trk=%h addr=%h data=%h dout=%h expected all 0",
                     wr_en, flush_req, flush_track, wr_addr, wr_data, dout);
        end
        res = 1'b0;
        check_status("reset_status", 8'h80);
    endtask

    task automatic test_basic_write();
        int lat = 0;
        atrack = 8'h05; head_pos = 13'h0100;
        exp_q.push_back({14'h0280, 8'h3C});
        exp_q.push_back({14'h0281, 8'h00});
        cpu_write(4'h5, 8'h3C);
        while (!wr_en && lat < 4 * BP) begin
            tick_wait(1);
            lat++;
        end
        checks++;
        if (lat != BP) begin
            errors++;
            $display("FAIL first_byte_latency: got %0d cycles expected %0d", lat, BP);
        end
        wait_pair("basic_pair");
        check_status("basic_status", 8'hC0);
        cpu_write(4'hC, 8'h00);
        tick_wait(1);
        check_flush("basic_flush", 1'b1, 8'h05);
        ack_flush();
        check_flush("basic_flush_done", 1'b0, 8'h00);
        check_status("basic_idle_status", 8'h80);
    endtask

    task automatic test_sync_tag();
        atrack = 8'h06; head_pos = 13'h0010;
        cpu_write(4'hB, 8'h00);
        exp_q.push_back({14'h0120, 8'hFF});
        exp_q.push_back({14'h0121, 8'h01});
        cpu_write(4'h5, 8'hFF);
        wait_pair("sync_pair");
        exp_q.push_back({14'h0122, 8'h12});
        exp_q.push_back({14'h0123, 8'h00});
        cpu_write(4'h5, 8'h12);
        wait_pair("sync_next_pair");
        cpu_write(4'hC, 8'h00);
        tick_wait(1);
        check_flush("sync_flush", 1'b1, 8'h06);
        ack_flush();
    endtask

    task automatic test_wrap();
        atrack = 8'h04; head_pos = 13'h193F;
        exp_q.push_back({14'h327E, 8'h11});
        exp_q.push_back({14'h327F, 8'h00});
        cpu_write(4'h5, 8'h11);
        wait_pair("wrap_pair0");
        exp_q.push_back({14'h0000, 8'h22});
        exp_q.push_back({14'h0001, 8'h00});
        cpu_write(4'h5, 8'h22);
        wait_pair("wrap_pair1");
        cpu_write(4'hC, 8'h00);
        ack_flush();
    endtask

    task automatic test_underrun();
        atrack = 8'h04; head_pos = 13'h0020;
        exp_q.push_back({14'h0040, 8'h33});
        exp_q.push_back({14'h0041, 8'h00});
        cpu_write(4'h5, 8'h33);
        wait_pair("underrun_first_pair");
`ifdef FDD840_UNDERRUN_FILL_EN
        exp_q.push_back({14'h0042, 8'hAA});
        exp_q.push_back({14'h0043, 8'h00});
        wait_pair("underrun_fill_pair");
        check_status("underrun_fill_status", 8'hE0);
        cpu_write(4'hC, 8'h00);
        tick_wait(1);
        check_flush("underrun_fill_flush", 1'b1, 8'h04);
`else
        tick_wait(2 * BP);
        check_flush("underrun_flush", 1'b1, 8'h04);
        check_status("underrun_status", 8'hA0);
`endif
        ack_flush();
    endtask

    task automatic test_flush();
        atrack = 8'h07; head_pos = 13'h0000;
        exp_q.push_back({14'h0180, 8'h01});
        exp_q.push_back({14'h0181, 8'h00});
        cpu_write(4'h5, 8'h01);
        check_status("flush_start_status", 8'h40);
        wait_pair("flush_pair0");
        exp_q.push_back({14'h0182, 8'h02});
        exp_q.push_back({14'h0183, 8'h00});
        cpu_write(4'h5, 8'h02);
        wait_pair("flush_pair1");
        exp_q.push_back({14'h0184, 8'h03});
        exp_q.push_back({14'h0185, 8'h00});
        cpu_write(4'h5, 8'h03);
        wait_pair("flush_pair2");
        cpu_write(4'hC, 8'h00);
        tick_wait(1);
        check_flush("flush_req_set", 1'b1, 8'h07);
        check_status("flush_status", 8'h80);
        // flush_ack and a start on the same edge: the start must be dropped.
        tick_wait(1);
        io_on = 1'b1; rw = 1'b0; address = 4'h5; din = 8'h55; flush_ack = 1'b1;
        tick_wait(1);
        io_on = 1'b0; flush_ack = 1'b0;
        check_flush("flush_ack_clears", 1'b0, 8'h00);
        tick_wait(BP + 4);
        check_status("ack_start_ignored", 8'h00);
    endtask

    task automatic test_track_change();
        atrack = 8'h09; head_pos = 13'h0005;
        exp_q.push_back({14'h008A, 8'h44});
        exp_q.push_back({14'h008B, 8'h00});
        cpu_write(4'h5, 8'h44);
        wait_wr_en("track_pair");
        atrack = 8'h0A;
        tick_wait(3);
        check_flush("track_change_flush", 1'b1, 8'h09);
        ack_flush();
        atrack = 8'h04;
        tick_wait(1);
        check_flush("track_change_done", 1'b0, 8'h00);
    endtask

    task automatic test_protect_and_reset();
        logic [7:0] st;
        wp = 1'b1;
        cpu_write(4'h5, 8'h77);
        tick_wait(3 * BP);
        cpu_read(4'h6, st);
        checks++;
        if ((st & 8'h70) !== 8'h10) begin
            errors++;
            $display("FAIL wp_start_ignored: status bits got %h expected %h", st & 8'h70, 8'h10);
        end
        wp = 1'b0;
        tick_wait(2);

        atrack = 8'h04; head_pos = 13'h0030;
        exp_q.push_back({14'h0060, 8'h66});
        exp_q.push_back({14'h0061, 8'h00});
        cpu_write(4'h5, 8'h66);
        wait_pair("wp_rise_pair");
        wp = 1'b1;
        tick_wait(2);
        check_flush("wp_rise_flush", 1'b1, 8'h04);
        ack_flush();
        wp = 1'b0;
        tick_wait(2);

        head_pos = 13'h0000;
        exp_q.push_back({14'h0000, 8'h5A});
        cpu_write(4'h5, 8'h5A);
        wait_wr_en("reset_mid_pair");
        res = 1'b1;
        tick_wait(1);
        res = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || flush_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write: wr_en=%b flush_req=%b expected 0 0", wr_en, flush_req);
        end
        check_status("reset_mid_status", 8'h80);
        tick_wait(2 * BP);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_sync_tag();
        test_wrap();
        test_underrun();
        test_flush();
        test_track_change();
        test_protect_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
